// File: rtl/spi_pkg.sv
// Shared SPI link definitions: frame layout and FSM state encoding.
// Used by both ends of the register-write link.
package spi_pkg;

  localparam int unsigned SPI_FRAME_W = 16;
  localparam int unsigned RW_BIT      = 15;
  localparam int unsigned ADDR_MSB    = 14;
  localparam int unsigned ADDR_LSB    = 8;
  localparam int unsigned DATA_MSB    = 7;
  localparam int unsigned DATA_LSB    = 0;

  typedef logic [2:0] spi_state_t;

  localparam spi_state_t StIdle  = 3'd0;
  localparam spi_state_t StSetup = 3'd1;
  localparam spi_state_t StHi    = 3'd2;
  localparam spi_state_t StLo    = 3'd3;
  localparam spi_state_t StHold  = 3'd4;
  localparam spi_state_t StGap   = 3'd5;

  function automatic int unsigned spi_max4(input int unsigned a, input int unsigned b,
                                           input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Down-counting phase timer: load N, expire pulses high on the N-th cycle after load.
// A load on the expiring cycle restarts the count, so phases chain back-to-back.
module spi_phase_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_q;
  logic         run_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (load) begin
      cnt_q <= load_val - W'(1);
      run_q <= 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) begin
        run_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - W'(1);
      end
    end
  end

  assign expire = run_q && (cnt_q == '0);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 controller: sends one 16-bit {rw, addr, data} frame MSB first per accepted start
// and captures the last 8 CIPO bits of read frames. All phases are multi-cycle.
module spi_controller
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 4,
  parameter int unsigned CS_HOLD  = 4,
  parameter int unsigned GAP      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  output logic       SCLK,
  output logic       COPI,
  output logic       nCS,
  input  logic       CIPO
);

  localparam int unsigned MAX_P = spi_max4(CLK_DIV, CS_SETUP, CS_HOLD, GAP);
  localparam int unsigned TW    = $clog2(MAX_P + 1);

  localparam logic [TW-1:0] SETUP_LD = TW'(CS_SETUP);
  localparam logic [TW-1:0] DIV_LD   = TW'(CLK_DIV);
  localparam logic [TW-1:0] HOLD_LD  = TW'(CS_HOLD);
  localparam logic [TW-1:0] GAP_LD   = TW'(GAP);

  spi_state_t             state_q, state_d;
  logic [SPI_FRAME_W-1:0] shreg_q;
  logic [SPI_FRAME_W-1:0] frame;
  logic [3:0]             bit_cnt_q;
  logic                   rw_q;
  logic [7:0]             rx_q;
  logic                   hi_entry_q;
  logic                   ncs_q;
  logic                   sclk_q;
  logic                   busy_q;
  logic                   done_q;
  logic [7:0]             rdata_q;
  logic                   rvalid_q;

  logic                   tmr_load;
  logic [TW-1:0]          tmr_val;
  logic                   tmr_expire;

  spi_phase_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  always_comb begin
    frame                     = '0;
    frame[RW_BIT]             = rw;
    frame[ADDR_MSB:ADDR_LSB]  = addr;
    frame[DATA_MSB:DATA_LSB]  = wdata;
  end

  // Every state transition reloads the timer with the length of the state being entered.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StSetup;
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
        end
      end
      StSetup: begin
        if (tmr_expire) begin
          state_d  = StHi;
          tmr_load = 1'b1;
          tmr_val  = DIV_LD;
        end
      end
      StHi: begin
        if (tmr_expire) begin
          tmr_load = 1'b1;
          if (bit_cnt_q == 4'd0) begin
            state_d = StHold;
            tmr_val = HOLD_LD;
          end else begin
            state_d = StLo;
            tmr_val = DIV_LD;
          end
        end
      end
      StLo: begin
        if (tmr_expire) begin
          state_d  = StHi;
          tmr_load = 1'b1;
          tmr_val  = DIV_LD;
        end
      end
      StHold: begin
        if (tmr_expire) begin
          state_d  = StGap;
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
        end
      end
      StGap: begin
        if (tmr_expire) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      bit_cnt_q  <= 4'd0;
      rw_q       <= 1'b0;
      rx_q       <= 8'h00;
      hi_entry_q <= 1'b0;
      ncs_q      <= 1'b1;
      sclk_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rdata_q    <= 8'h00;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= 1'b0;
      rvalid_q   <= 1'b0;
      hi_entry_q <= (state_d == StHi) && (state_q != StHi);
      // CIPO is taken at the end of the first SCLK-high cycle; the last 8 samples are the reply.
      if (hi_entry_q) begin
        rx_q <= {rx_q[6:0], CIPO};
      end
      case (state_q)
        StIdle: begin
          if (start) begin
            shreg_q   <= frame;
            bit_cnt_q <= 4'd15;
            rw_q      <= rw;
            ncs_q     <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        StSetup: begin
          if (tmr_expire) sclk_q <= 1'b1;
        end
        StHi: begin
          if (tmr_expire) begin
            sclk_q <= 1'b0;
            if (bit_cnt_q != 4'd0) begin
              shreg_q   <= {shreg_q[SPI_FRAME_W-2:0], 1'b0};
              bit_cnt_q <= bit_cnt_q - 4'd1;
            end
          end
        end
        StLo: begin
          if (tmr_expire) sclk_q <= 1'b1;
        end
        StHold: begin
          if (tmr_expire) begin
            ncs_q  <= 1'b1;
            done_q <= 1'b1;
            if (!rw_q) begin
              rdata_q  <= rx_q;
              rvalid_q <= 1'b1;
            end
          end
        end
        StGap: begin
          if (tmr_expire) busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rvalid_q;
  assign SCLK        = sclk_q;
  assign COPI        = shreg_q[SPI_FRAME_W-1];
  assign nCS         = ncs_q;

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller: default-timing instance plus a minimum-timing instance.
module tb_spi_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start, rw, busy, done, rdata_valid, sclk, copi, ncs, cipo;
  logic [6:0] addr;
  logic [7:0] wdata, rdata;

  logic       start_b, rw_b, busy_b, done_b, rdata_valid_b, sclk_b, copi_b, ncs_b;
  logic [6:0] addr_b;
  logic [7:0] wdata_b, rdata_b;

  spi_controller dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .rw          (rw),
    .addr        (addr),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .SCLK        (sclk),
    .COPI        (copi),
    .nCS         (ncs),
    .CIPO        (cipo)
  );

  spi_controller #(
    .CLK_DIV  (2),
    .CS_SETUP (1),
    .CS_HOLD  (1),
    .GAP      (1)
  ) dut_b (
    .clk         (clk),
    .rst         (rst),
    .start       (start_b),
    .rw          (rw_b),
    .addr        (addr_b),
    .wdata       (wdata_b),
    .busy        (busy_b),
    .done        (done_b),
    .rdata       (rdata_b),
    .rdata_valid (rdata_valid_b),
    .SCLK        (sclk_b),
    .COPI        (copi_b),
    .nCS         (ncs_b),
    .CIPO        (1'b0)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  typedef struct {
    logic [15:0] frame;
    logic        rd;
    logic [7:0]  rdata;
    int unsigned done_cyc;
    int unsigned busy_fall;
  } exp_t;

  exp_t sb[$];

  function automatic void push(input logic [15:0] f, input logic r, input logic [7:0] d,
                               input int unsigned c);
    sb.push_back('{f, r, d, c + 133, c + 137});
  endfunction

  // Reply model: presents the next bit of cipo_word after every SCLK fall, MSB at nCS fall.
  logic [15:0] cipo_word = 16'h0000;
  logic        c_prev_ncs = 1'b1, c_prev_sclk = 1'b0;
  int          cidx = 0;
  always @(negedge clk) begin
    if (c_prev_ncs && !ncs) begin
      cipo = cipo_word[15];
      cidx = 1;
    end else if (!ncs && c_prev_sclk && !sclk && cidx < 16) begin
      cipo = cipo_word[15-cidx];
      cidx++;
    end
    c_prev_ncs  = ncs;
    c_prev_sclk = sclk;
  end

  // Monitor for the default instance: rebuilds each frame from the wire and checks on done.
  logic        m_prev_ncs = 1'b1, m_prev_sclk = 1'b0, m_prev_busy = 1'b0;
  logic [15:0] m_frame;
  int          m_rises, m_low;
  int          frames_a = 0;
  bit          busy_pending = 1'b0;
  int unsigned pend_busy;
  exp_t        e;

  always @(negedge clk) begin
    if (rst) begin
      m_prev_ncs   = 1'b1;
      m_prev_sclk  = 1'b0;
      m_prev_busy  = 1'b0;
      busy_pending = 1'b0;
    end else begin
      if (m_prev_ncs && !ncs) begin
        m_frame  = 16'h0;
        m_rises  = 0;
        m_low    = 0;
        frames_a++;
      end
      if (!ncs) begin
        m_low++;
        if (sclk && !m_prev_sclk) begin
          m_frame = {m_frame[14:0], copi};
          m_rises++;
        end
      end
      if (done) begin
        if (sb.size() == 0) begin
          flag("unexpected_done");
        end else begin
          e = sb.pop_front();
          chk("frame_bits", m_frame, e.frame);
          chk("sclk_rises", m_rises, 16);
          chk("ncs_low_cycles", m_low, 132);
          chk("ncs_high_at_done", ncs, 1'b1);
          chk("done_cycle", cyc, e.done_cyc);
          chk("rdata_valid", rdata_valid, e.rd);
          chk("rdata", rdata, e.rdata);
          busy_pending = 1'b1;
          pend_busy    = e.busy_fall;
        end
      end else if (rdata_valid) begin
        flag("rdata_valid_without_done");
      end
      if (m_prev_busy && !busy) begin
        if (busy_pending) chk("busy_fall_cycle", cyc, pend_busy);
        else flag("unexpected_busy_fall");
        busy_pending = 1'b0;
      end
      m_prev_ncs  = ncs;
      m_prev_sclk = sclk;
      m_prev_busy = busy;
    end
  end

  task automatic issue(input logic r, input logic [6:0] a, input logic [7:0] d,
                       input logic [15:0] f, input logic [7:0] exp_rd);
    @(negedge clk);
    push(f, !r, exp_rd, cyc);
    rw    = r;
    addr  = a;
    wdata = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) flag("timeout_waiting_idle");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c;
    int          n, low, rises, bad_period;
    int unsigned last_rise;
    logic        prev;
    logic [15:0] fb;

    rst = 1'b1;
    start = 1'b0; rw = 1'b0; addr = 7'h0; wdata = 8'h0; cipo = 1'b0;
    start_b = 1'b0; rw_b = 1'b0; addr_b = 7'h0; wdata_b = 8'h0;
    repeat (3) @(negedge clk);
    chk("reset_ncs", ncs, 1'b1);
    chk("reset_sclk", sclk, 1'b0);
    chk("reset_copi", copi, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_rdata", rdata, 8'h00);
    chk("reset_rdata_valid", rdata_valid, 1'b0);
    rst = 1'b0;

    // Reset in the middle of a high phase abandons the frame without a done pulse.
    @(negedge clk);
    rw = 1'b1; addr = 7'h05; wdata = 8'h5A; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!sclk && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) flag("timeout_first_sclk");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midframe_rst_ncs", ncs, 1'b1);
    chk("midframe_rst_sclk", sclk, 1'b0);
    chk("midframe_rst_busy", busy, 1'b0);
    chk("midframe_rst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);

    // Plain write.
    issue(1'b1, 7'h02, 8'hA5, 16'h82A5, 8'h00);
    wait_idle(400);

    // Back-to-back with start held high; inputs change after the first accept.
    cipo_word = 16'h5AA5;
    @(negedge clk);
    c = cyc;
    push(16'hFF00, 1'b0, 8'h00, c);
    push(16'h10C3, 1'b1, 8'hA5, c + 137);
    rw = 1'b1; addr = 7'h7F; wdata = 8'h00; start = 1'b1;
    repeat (5) @(negedge clk);
    rw = 1'b0; addr = 7'h10; wdata = 8'hC3;
    repeat (140) @(negedge clk);
    start = 1'b0;
    wait_idle(600);

    // Stray start pulses while busy, including the last GAP cycle, are ignored.
    @(negedge clk);
    c = cyc;
    push(16'h830F, 1'b0, 8'hA5, c);
    rw = 1'b1; addr = 7'h03; wdata = 8'h0F; start = 1'b1;
    for (int k = 1; k <= 137; k++) begin
      @(negedge clk);
      start = (k == 20 || k == 80 || k == 136);
      addr  = 7'h55;
    end
    start = 1'b0;
    wait_idle(400);

    // Read, then a write that must leave rdata alone.
    cipo_word = 16'hC33C;
    issue(1'b0, 7'h04, 8'h00, 16'h0400, 8'h3C);
    wait_idle(400);
    issue(1'b1, 7'h01, 8'h55, 16'h8155, 8'h3C);
    wait_idle(400);
    repeat (10) @(negedge clk);
    chk("frame_count", frames_a, 7);
    chk("scoreboard_empty", sb.size(), 0);

    // Minimum-timing instance.
    @(negedge clk);
    c = cyc;
    rw_b = 1'b1; addr_b = 7'h31; wdata_b = 8'hE7; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    n = 0; low = 0; rises = 0; bad_period = 0; last_rise = 0; prev = 1'b0; fb = 16'h0;
    while (!done_b && n < 200) begin
      if (!ncs_b) low++;
      if (sclk_b && !prev) begin
        fb = {fb[14:0], copi_b};
        if (rises > 0 && cyc - last_rise != 4) bad_period++;
        last_rise = cyc;
        rises++;
      end
      prev = sclk_b;
      @(negedge clk);
      n++;
    end
    if (n >= 200) flag("timeout_b_done");
    chk("b_ncs_low_cycles", low, 64);
    chk("b_sclk_rises", rises, 16);
    chk("b_sclk_bad_periods", bad_period, 0);
    chk("b_frame_bits", fb, 16'hB1E7);
    chk("b_done_cycle", cyc, c + 65);
    chk("b_busy_at_done", busy_b, 1'b1);
    @(negedge clk);
    chk("b_busy_after_gap", busy_b, 1'b0);
    chk("b_rdata_valid", rdata_valid_b, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
